// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit of out-of-order writebacks, with branch-mispredict flush.
// Optional event counters (perf_commits, perf_flushes) are built when ROB_PERF_CNT_EN is defined.
module reorder_buffer #(
    parameter int ROB_BIT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    input  logic [1:0]         issue_type,
    input  logic [4:0]         issue_rd,
    input  logic               issue_pred_taken,
    output logic               full,
    output logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               wb_valid,
    input  logic [ROB_BIT-1:0] wb_entry,
    input  logic [31:0]        wb_value,
    input  logic               wb_mispredict,
    input  logic [ROB_BIT-1:0] get_rob_entry1,
    output logic               ready1,
    output logic [31:0]        value1,
    input  logic [ROB_BIT-1:0] get_rob_entry2,
    output logic               ready2,
    output logic [31:0]        value2,
    output logic               rob_commit,
    output logic [4:0]         commit_reg_id,
    output logic [31:0]        commit_reg_data,
    output logic [ROB_BIT-1:0] commit_rob_entry,
    output logic               rob_clear_up,
    output logic [31:0]        clear_pc,
    output logic               debug_rob_empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_commits,
    output logic [31:0]        perf_flushes
`endif
);

    localparam int DEPTH = 1 << ROB_BIT;
    localparam logic [ROB_BIT:0]   CNT_FULL = (ROB_BIT+1)'(DEPTH);
    localparam logic [ROB_BIT:0]   CNT_ZERO = (ROB_BIT+1)'(32'd0);
    localparam logic [ROB_BIT:0]   CNT_ONE  = (ROB_BIT+1)'(32'd1);
    localparam logic [ROB_BIT-1:0] PTR_ZERO = ROB_BIT'(32'd0);
    localparam logic [ROB_BIT-1:0] PTR_ONE  = ROB_BIT'(32'd1);
    localparam logic [1:0]         TYPE_REG    = 2'd0;
    localparam logic [1:0]         TYPE_BRANCH = 2'd1;

    logic        entry_valid [DEPTH];
    logic        entry_ready [DEPTH];
    logic [1:0]  entry_type  [DEPTH];
    logic [4:0]  entry_rd    [DEPTH];
    logic        entry_pred  [DEPTH];
    logic [31:0] entry_value [DEPTH];
    logic        entry_mis   [DEPTH];

    logic [ROB_BIT-1:0] head;
    logic [ROB_BIT-1:0] tail;
    logic [ROB_BIT:0]   count;

    logic do_commit;
    logic do_flush;
    logic do_issue;
    logic do_wb;
    logic head_pred_unused;

    assign full             = (count == CNT_FULL) | rob_clear_up;
    assign issue_rob_entry  = tail;
    assign debug_rob_empty  = (count == CNT_ZERO) & ~rob_commit;
    // Predicted direction is kept per entry for tracing; nothing downstream consumes it yet.
    assign head_pred_unused = entry_pred[head];

    // Per-edge actions; a flushing commit suppresses the same-edge issue and writeback.
    always_comb begin
        do_commit = 1'b0;
        do_flush  = 1'b0;
        if (count != CNT_ZERO && entry_ready[head]) begin
            do_commit = 1'b1;
            do_flush  = (entry_type[head] == TYPE_BRANCH) & entry_mis[head];
        end else begin
            do_commit = 1'b0;
            do_flush  = 1'b0;
        end
        do_issue = issue_valid & ~full & ~do_flush;
        do_wb    = wb_valid & entry_valid[wb_entry] & ~rob_clear_up & ~do_flush;
    end

    // Operand lookups with bypass of the writeback arriving this cycle.
    always_comb begin
        ready1 = entry_ready[get_rob_entry1];
        value1 = entry_value[get_rob_entry1];
        ready2 = entry_ready[get_rob_entry2];
        value2 = entry_value[get_rob_entry2];
        if (wb_valid && wb_entry == get_rob_entry1) begin
            ready1 = 1'b1;
            value1 = wb_value;
        end else begin
            ready1 = entry_ready[get_rob_entry1];
            value1 = entry_value[get_rob_entry1];
        end
        if (wb_valid && wb_entry == get_rob_entry2) begin
            ready2 = 1'b1;
            value2 = wb_value;
        end else begin
            ready2 = entry_ready[get_rob_entry2];
            value2 = entry_value[get_rob_entry2];
        end
    end

    // Entry storage, pointers, occupancy and registered commit/flush outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ready[i] <= 1'b0;
                entry_type[i]  <= 2'd0;
                entry_rd[i]    <= 5'd0;
                entry_pred[i]  <= 1'b0;
                entry_value[i] <= 32'd0;
                entry_mis[i]   <= 1'b0;
            end
            head             <= PTR_ZERO;
            tail             <= PTR_ZERO;
            count            <= CNT_ZERO;
            rob_commit       <= 1'b0;
            commit_reg_id    <= 5'd0;
            commit_reg_data  <= 32'd0;
            commit_rob_entry <= PTR_ZERO;
            rob_clear_up     <= 1'b0;
            clear_pc         <= 32'd0;
        end else if (rdy_in) begin
            rob_commit       <= do_commit;
            commit_reg_id    <= (do_commit && entry_type[head] == TYPE_REG) ? entry_rd[head] : 5'd0;
            commit_reg_data  <= do_commit ? entry_value[head] : 32'd0;
            commit_rob_entry <= do_commit ? head : PTR_ZERO;
            rob_clear_up     <= do_flush;
            clear_pc         <= do_flush ? entry_value[head] : 32'd0;
            if (do_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entry_valid[i] <= 1'b0;
                    entry_ready[i] <= 1'b0;
                end
                head  <= PTR_ZERO;
                tail  <= PTR_ZERO;
                count <= CNT_ZERO;
            end else begin
                if (do_wb) begin
                    entry_ready[wb_entry] <= 1'b1;
                    entry_value[wb_entry] <= wb_value;
                    entry_mis[wb_entry]   <= wb_mispredict;
                end
                // Ready is dropped with valid so a retired slot never looks complete.
                if (do_commit) begin
                    entry_valid[head] <= 1'b0;
                    entry_ready[head] <= 1'b0;
                    head              <= head + PTR_ONE;
                end
                if (do_issue) begin
                    entry_valid[tail] <= 1'b1;
                    entry_ready[tail] <= 1'b0;
                    entry_type[tail]  <= issue_type;
                    entry_rd[tail]    <= issue_rd;
                    entry_pred[tail]  <= issue_pred_taken;
                    entry_mis[tail]   <= 1'b0;
                    tail              <= tail + PTR_ONE;
                end
                case ({do_issue, do_commit})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Commit and flush event counters, wrapping at 2^32.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_commits <= 32'd0;
            perf_flushes <= 32'd0;
        end else if (rdy_in) begin
            if (do_commit) perf_commits <= perf_commits + 32'd1;
            if (do_flush)  perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter: ROB_BIT, 3, entry index width; depth DEPTH = 2^ROB_BIT.
REQ-002 SHALL have ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset.
- rdy_in  in  1  pause when low.
REQ-003 SHALL have issue ports:
- issue_valid  in  1  new instruction.
- issue_type  in  2  0=reg-write, 1=branch, 2=store.
- issue_rd  in  5  destination register.
- issue_pred_taken  in  1  predicted direction.
- full  out  1  no space.
- issue_rob_entry  out  ROB_BIT  tail index.
REQ-004 SHALL have writeback ports:
- wb_valid  in  1  result valid.
- wb_entry  in  ROB_BIT  target entry.
- wb_value  in  32  result; for a branch, the correct next PC.
- wb_mispredict  in  1  branch mispredicted.
REQ-005 SHALL have lookup ports, for n=1,2:
- get_rob_entryn  in  ROB_BIT  queried entry.
- readyn  out  1  result available.
- valuen  out  32  result.
REQ-006 SHALL have commit and flush ports:
- rob_commit  out  1  commit pulse.
- commit_reg_id  out  5  committed register.
- commit_reg_data  out  32  committed value.
- commit_rob_entry  out  ROB_BIT  committed entry.
- rob_clear_up  out  1  flush pulse.
- clear_pc  out  32  redirect PC.
- debug_rob_empty  out  1  buffer empty.
REQ-007 SHALL use one clock clk_in; rst_in is synchronous, active-high.

Function
REQ-008 SHALL be a circular buffer with head, tail and count; both pointers wrap modulo DEPTH.
REQ-009 SHALL drive full = (count==DEPTH) | rob_clear_up, combinationally; issue_rob_entry = tail.
REQ-010 SHALL, on an edge with issue_valid & !full, write the entry at tail (valid=1, ready=0, type, rd, pred) and advance tail.
REQ-011 SHALL, on wb_valid to a valid entry, set ready=1 and store wb_value and wb_mispredict; writeback to an invalid entry SHALL be ignored.
REQ-012 SHALL drive readyn/valuen combinationally from the entry, bypassing the same-cycle writeback when wb_valid & wb_entry==get_rob_entryn.
REQ-013 SHALL commit at most one entry per cycle, when count>0 and the head entry is ready (stored ready only, no bypass).
REQ-014 SHALL register commit outputs; rob_commit is high exactly one cycle after the commit edge; otherwise rob_commit=0 and the other commit outputs are 0.
REQ-015 SHALL drive commit_reg_id = rd for reg-write entries and 0 for branch/store entries; commit_reg_data = stored value; commit_rob_entry = head.
REQ-016 SHALL, on simultaneous commit and issue, leave count unchanged; at most one commit and one issue occur per edge.
REQ-017 SHALL, when a committing branch has mispredict=1:
- clear all valid bits;
- reset head, tail and count to 0;
- drive rob_clear_up=1 and clear_pc=stored value for exactly the next cycle.
REQ-018 SHALL drop any issue on the mispredict-commit edge and while rob_clear_up is high; writebacks in those cycles SHALL be ignored.
REQ-019 SHALL still assert rob_commit for the mispredicted branch in the same cycle as rob_clear_up (commit_reg_id=0).
REQ-020 SHALL drive debug_rob_empty = (count==0) & !rob_commit.
REQ-021 SHALL, while rdy_in is low, hold all state and registered outputs unchanged and perform no issue, writeback or commit.

Reset
REQ-022 SHALL, on rst_in:
- clear every entry and set head=tail=count=0;
- drive rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry, rob_clear_up and clear_pc to 0.
REQ-023 SHALL give rst_in priority over rdy_in and all other inputs; reset mid-flush drops the flush.

Configuration
REQ-024 SHALL, with ROB_PERF_CNT_EN defined, add outputs perf_commits (32) and perf_flushes (32):
- both reset to 0;
- incremented per commit and per flush, wrapping at 2^32.
REQ-025 SHALL, without ROB_PERF_CNT_EN, omit those ports and counters; all other behaviour is identical.

Verification
REQ-026 SHALL cover these scenarios (ROB_BIT=3):
- Reset then idle -> full=0, debug_rob_empty=1, rob_commit=0.
- Issue rd=5 at entry 0, wb value 0x1234 -> next cycle rob_commit=1, commit_reg_id=5, commit_reg_data=0x1234, commit_rob_entry=0.
- Issue 8 entries with no writeback -> full=1; a 9th issue is ignored and tail stays 0 after wrap.
- Entries 0,1 issued, writeback entry 1 then entry 0 -> commits of 0 then 1, in order, on consecutive cycles.
- Branch at entry 2, wb_mispredict=1, wb_value=0x80 -> rob_clear_up=1 with clear_pc=0x80 for one cycle; issue in that cycle dropped; next cycle debug_rob_empty=1.
- Same-cycle writeback to the queried entry -> ready1=1 and value1=wb_value combinationally; rdy_in low for 3 cycles -> state frozen.
